// File: rtl/uart_rx_oversampled_pkg.sv
// Shared UART receiver definitions: FSM state encoding, the baud divider
// calculation and the 3-sample majority helper.
`timescale 1ns/1ps

package uart_rx_oversampled_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_e;

    // Clocks per oversample tick, truncated.
    function automatic int unsigned uart_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned os);
        return clk_freq / (baud * os);
    endfunction

    // Majority of three line samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_oversampled_if.sv
// Byte delivery handshake from the UART receiver to its consumer.
`timescale 1ns/1ps

interface uart_rx_oversampled_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 valid;
    logic                 ready;

    // Receiver side: produces data_out/valid, observes ready.
    modport master (
        output data_out,
        output valid,
        input  ready
    );

    // Consumer side.
    modport slave (
        input  data_out,
        input  valid,
        output ready
    );
endinterface

// File: rtl/uart_rx_oversampled_baud_tick_gen.sv
// Oversample tick generator: one-cycle tick every DIV clocks, restartable.
`timescale 1ns/1ps

module uart_baud_tick_gen #(
    parameter int unsigned DIV = 100
) (
    input  logic clk,
    input  logic srst,
    input  logic restart_i,
    output logic tick_o
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap after DIV clocks, restart forces phase zero.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // Divider counter.
    always_ff @(posedge clk or negedge srst) begin
        if (!srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST) && !restart_i;

endmodule

// File: rtl/uart_rx_oversampled.sv
// UART 8N1 receiver: 2-FF input synchronizer, oversampled bit timing with a
// mid-bit 3-sample majority vote, frame FSM and a valid/ready output register.
`timescale 1ns/1ps

module uart_rx_oversampled
    import uart_rx_oversampled_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 2400,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  rx,
    uart_rx_oversampled_if.master out_if,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  overrun
);
    localparam int unsigned DIV = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned SW  = $clog2(OVERSAMPLE);
    localparam int unsigned BW  = $clog2(DATA_BITS + 1);

    localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    logic                 rx_meta_q;
    logic                 rx_s_q;
    uart_rx_state_e       state_q;
    logic [SW-1:0]        scnt_q;
    logic [SW-1:0]        scnt_d;
    logic [BW-1:0]        bcnt_q;
    logic                 samp_lo_q;
    logic                 samp_mid_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 busy_q;
    logic                 ferr_q;
    logic                 ovr_q;

    logic tick;
    logic start_det;
    logic vote_d;
    logic vote_now;
    logic can_load;

    uart_baud_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk       (clk),
        .srst      (srst),
        .restart_i (start_det),
        .tick_o    (tick)
    );

    // Decode of the current state/sample position.
    always_comb begin
        start_det = (state_q == IDLE) && !rx_s_q;
        scnt_d    = (scnt_q == S_LAST) ? '0 : scnt_q + SW'(1);
        vote_d    = maj3(samp_lo_q, samp_mid_q, rx_s_q);
        vote_now  = tick && (scnt_q == S_HI);
        can_load  = !valid_q || out_if.ready;
    end

    // Two-flop synchronizer for the asynchronous serial line.
    always_ff @(posedge clk or negedge srst) begin
        if (!srst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Frame FSM with sample counter, shift register and registered outputs.
    always_ff @(posedge clk or negedge srst) begin
        if (!srst) begin
            state_q    <= IDLE;
            scnt_q     <= '0;
            bcnt_q     <= '0;
            samp_lo_q  <= 1'b1;
            samp_mid_q <= 1'b1;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;

            // A load later in this block overrides the clear, so accept+load keeps valid high.
            if (valid_q && out_if.ready) begin
                valid_q <= 1'b0;
            end

            if (tick && (state_q != IDLE)) begin
                scnt_q <= scnt_d;
                if (scnt_q == S_LO) begin
                    samp_lo_q <= rx_s_q;
                end
                if (scnt_q == S_MID) begin
                    samp_mid_q <= rx_s_q;
                end
            end

            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                        scnt_q  <= '0;
                        bcnt_q  <= '0;
                    end
                end
                START: begin
                    if (vote_now) begin
                        if (!vote_d) begin
                            state_q <= DATA;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (vote_now) begin
                        shift_q <= {vote_d, shift_q[DATA_BITS-1:1]};
                        if (bcnt_q == B_LAST) begin
                            state_q <= STOP;
                        end else begin
                            bcnt_q <= bcnt_q + BW'(1);
                        end
                    end
                end
                STOP: begin
                    if (vote_now) begin
                        if (vote_d) begin
                            if (can_load) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                ovr_q <= 1'b1;
                            end
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rx_s_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_if.data_out = data_q;
    assign out_if.valid    = valid_q;
    assign busy            = busy_q;
    assign frame_err       = ferr_q;
    assign overrun         = ovr_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: frames driven bit by bit on rx,
// outputs sampled on the falling clock edge.
`timescale 1ns/1ps

module tb_uart_rx_oversampled;
    // 768 kHz / (2400 * 16) gives a divider of 20, i.e. 320 clocks per bit.
    localparam int unsigned CLK_FREQ = 768_000;
    localparam int unsigned BAUD     = 2400;
    localparam int unsigned OS       = 16;
    localparam int unsigned BIT_CLK  = 320;

    logic clk = 1'b0;
    logic srst;
    logic rx;
    logic busy;
    logic frame_err;
    logic overrun;

    uart_rx_oversampled_if #(.DATA_BITS(8)) rx_if ();

    uart_rx_oversampled #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD),
        .OVERSAMPLE (OS),
        .DATA_BITS  (8)
    ) dut (
        .clk       (clk),
        .srst      (srst),
        .rx        (rx),
        .out_if    (rx_if.master),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Event counters observed on the falling edge.
    int unsigned n_xfer    = 0;
    int unsigned n_ferr    = 0;
    int unsigned n_ovr     = 0;
    int unsigned n_vhi     = 0;
    int unsigned rise_cyc  = 0;
    int unsigned start_cyc = 0;
    logic [7:0]  last_data = 8'h00;
    logic        valid_prev = 1'b0;

    always @(negedge clk) begin
        if (rx_if.valid === 1'b1) n_vhi++;
        if (rx_if.valid === 1'b1 && valid_prev !== 1'b1) rise_cyc = cyc;
        valid_prev = rx_if.valid;
        if (rx_if.valid === 1'b1 && rx_if.ready === 1'b1) begin
            n_xfer++;
            last_data = rx_if.data_out;
        end
        if (frame_err === 1'b1) n_ferr++;
        if (overrun === 1'b1) n_ovr++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic wait_clk(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives start, 8 data bits LSB first, and the given stop level.
    // glitch_d0 puts a single-clock high pulse in the middle of D0.
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit glitch_d0);
        start_cyc = cyc;
        rx = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (glitch_d0 && i == 0) begin
                wait_clk(BIT_CLK / 2);
                rx = 1'b1;
                wait_clk(1);
                rx = b[0];
                wait_clk(BIT_CLK / 2 - 1);
            end else begin
                wait_clk(BIT_CLK);
            end
        end
        rx = stop;
        wait_clk(BIT_CLK);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    int unsigned vhi0;
    int unsigned lat;

    initial begin
        srst = 1'b0;
        rx = 1'b1;
        rx_if.ready = 1'b1;
        wait_clk(5);
        @(negedge clk);
        check("rst_valid", rx_if.valid, 0);
        check("rst_data", rx_if.data_out, 0);
        check("rst_busy", busy, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        wait_clk(1);
        srst = 1'b1;
        wait_clk(20);

        // 1: plain byte with ready high
        vhi0 = n_vhi;
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_clk(BIT_CLK);
        @(negedge clk);
        lat = rise_cyc - start_cyc;
        check("t1_xfer", n_xfer, 1);
        check("t1_data", last_data, 8'hA5);
        check("t1_valid_cycles", n_vhi - vhi0, 1);
        check("t1_ferr", n_ferr, 0);
        check("t1_ovr", n_ovr, 0);
        check("t1_busy", busy, 0);
        check("t1_latency_window", (lat >= 19 * BIT_CLK / 2) && (lat <= 39 * BIT_CLK / 4), 1);

        // 2: overrun while the consumer stalls
        wait_clk(1);
        rx_if.ready = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        wait_clk(BIT_CLK);
        @(negedge clk);
        check("t2_data_held", rx_if.data_out, 8'h3C);
        check("t2_valid_held", rx_if.valid, 1);
        check("t2_ovr", n_ovr, 1);
        check("t2_no_xfer", n_xfer, 1);
        wait_clk(1);
        rx_if.ready = 1'b1;
        wait_clk(2);
        @(negedge clk);
        check("t2_valid_drop", rx_if.valid, 0);
        check("t2_xfer", n_xfer, 2);
        check("t2_xfer_data", last_data, 8'h3C);
        check("t2_ovr_once", n_ovr, 1);

        // 3: stop bit low, line held low, then a good frame
        wait_clk(1);
        send_frame(8'h55, 1'b0, 1'b0);
        @(negedge clk);
        check("t3_ferr", n_ferr, 1);
        check("t3_busy_break", busy, 1);
        check("t3_no_xfer", n_xfer, 2);
        wait_clk(2 * BIT_CLK);
        @(negedge clk);
        check("t3_ferr_once", n_ferr, 1);
        check("t3_busy_held", busy, 1);
        wait_clk(1);
        rx = 1'b1;
        wait_clk(BIT_CLK / 4);
        @(negedge clk);
        check("t3_busy_release", busy, 0);
        wait_clk(BIT_CLK);
        send_frame(8'h12, 1'b1, 1'b0);
        wait_clk(BIT_CLK);
        @(negedge clk);
        check("t3_xfer", n_xfer, 3);
        check("t3_data", last_data, 8'h12);

        // 4: short low pulse is rejected
        wait_clk(1);
        rx = 1'b0;
        wait_clk(BIT_CLK / 4);
        rx = 1'b1;
        wait_clk(2 * BIT_CLK);
        @(negedge clk);
        check("t4_busy", busy, 0);
        check("t4_no_xfer", n_xfer, 3);
        check("t4_no_ferr", n_ferr, 1);
        check("t4_no_ovr", n_ovr, 1);
        wait_clk(1);
        send_frame(8'h81, 1'b1, 1'b0);
        wait_clk(BIT_CLK);
        @(negedge clk);
        check("t4_xfer", n_xfer, 4);
        check("t4_data", last_data, 8'h81);

        // 5: mid-bit glitch on D0 is outvoted
        wait_clk(1);
        send_frame(8'h00, 1'b1, 1'b1);
        wait_clk(BIT_CLK);
        @(negedge clk);
        check("t5_xfer", n_xfer, 5);
        check("t5_data", last_data, 8'h00);

        // 6: reset in the middle of D4, then a clean frame
        wait_clk(1);
        rx_if.ready = 1'b0;
        send_frame(8'h7E, 1'b1, 1'b0);
        wait_clk(BIT_CLK / 2);
        @(negedge clk);
        check("t6_pre_valid", rx_if.valid, 1);
        check("t6_pre_data", rx_if.data_out, 8'h7E);
        wait_clk(1);
        rx = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            rx = (i < 2) ? 1'b1 : 1'b0;
            wait_clk(BIT_CLK);
        end
        rx = 1'b0;
        wait_clk(BIT_CLK / 2);
        srst = 1'b0;
        wait_clk(3);
        @(negedge clk);
        check("t6_rst_valid", rx_if.valid, 0);
        check("t6_rst_data", rx_if.data_out, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ferr", frame_err, 0);
        check("t6_rst_ovr", overrun, 0);
        wait_clk(1);
        rx = 1'b1;
        wait_clk(BIT_CLK / 4);
        srst = 1'b1;
        rx_if.ready = 1'b1;
        wait_clk(BIT_CLK);
        send_frame(8'hC3, 1'b1, 1'b0);
        wait_clk(BIT_CLK);
        @(negedge clk);
        check("t6_xfer", n_xfer, 6);
        check("t6_data", last_data, 8'hC3);
        check("t6_data_reg", rx_if.data_out, 8'hC3);
        check("t6_ferr_total", n_ferr, 1);
        check("t6_ovr_total", n_ovr, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
